hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard resolver for the 5-stage MIPS core.
- Consumes the stage-tagged control bits the controller emits (memtoreg/regwrite in E/M/W, branchD/bneD) plus register specifiers from the datapath.
- Returns the flushE the controller consumes, and the stall and forward selects to the datapath.
- Adds a data-memory wait FSM so a slow dmem freezes the pipe, plus a stall-cycle counter for performance monitoring.

Parameters:
- TIMEOUT, 16: max consecutive dmem wait cycles before mem_err is set.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- rsD, rtD  in  5  source registers in Decode.
- rsE, rtE  in  5  source registers in Execute.
- writeregE, writeregM, writeregW  in  5  destination registers per stage.
- regwriteE, regwriteM, regwriteW  in  1  register-write enables per stage.
- memtoregE, memtoregM  in  1  load in E / M.
- branchD, bneD  in  1  beq / bne in Decode.
- memaccessM  in  1  load or store in M.
- dmem_ready  in  1  dmem completes the M-stage access this cycle.
- stallF, stallD, stallE, stallM  out  1  hold stage registers.
- flushE, flushW  out  1  insert bubble into E / W.
- forwardaD, forwardbD  out  1  Decode comparator takes aluoutM.
- forwardaE, forwardbE  out  2  ALU operand select.
- mem_err  out  1  sticky dmem timeout flag.
- stall_cnt  out  CNT_W  count of cycles with stallD=1.

Behaviour:
- Reset state (reset=0):
  - FSM enters IDLE; wait_cnt=0, mem_err=0, stall_cnt=0.
  - All stall/flush outputs are 0 and forwards are FWD_NONE, combinationally, while reset=0.
- Forward E (rsE shown; rtE identical):
  - FWD_MEM (10) if rsE!=0 && rsE==writeregM && regwriteM.
  - Else FWD_WB (01) if rsE!=0 && rsE==writeregW && regwriteW.
  - Else FWD_NONE (00).
  - M has priority over W when both match.
- Forward D: forwardaD = rsD!=0 && rsD==writeregM && regwriteM. Same for rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD).
- branchstall = (branchD|bneD) && ((regwriteE && writeregE!=0 && writeregE∈{rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM∈{rsD,rtD})).
- memstall = memaccessM && !dmem_ready.
  - Combinational, so it takes effect in the same cycle.
  - It is not gated by FSM state.
- Output equations:
  - stallF = stallD = lwstall | branchstall | memstall.
  - stallE = stallM = memstall.
  - flushE = (lwstall | branchstall) && !memstall, because E is frozen during a memstall.
  - flushW = memstall.
- Wait FSM, states IDLE and WAIT:
  - IDLE → WAIT when memstall; wait_cnt←1.
  - WAIT: if dmem_ready or !memaccessM → IDLE, wait_cnt←0. Otherwise wait_cnt increments, saturating at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, mem_err←1. It stays set until reset; the pipe stays stalled (no auto-abort).
  - A back-to-back access (ready, then a new access not ready in the next cycle) goes WAIT → IDLE → WAIT; wait_cnt restarts at 1.
- stall_cnt:
  - Increments on each clk edge where stallD=1.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-WAIT: immediate return to IDLE; counters cleared asynchronously.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - memwait_state_t enum: IDLE, WAIT.
  - REG_ZERO=5'd0.
- One sub-module, hazard_memwait: the FSM plus wait_cnt and mem_err. Inputs memaccessM and dmem_ready; outputs memstall and mem_err.
- Forward/stall logic and stall_cnt stay in the top module.

Test Plan:
- Forward E: writeregM=5, regwriteM=1, writeregW=5, regwriteW=1, rsE=5 → forwardaE=10. Same with regwriteM=0 → 01. rsE=0 with any match → 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1, stallE=0. Next cycle with memtoregE=0 → all 0; stall_cnt=1.
- Branch hazard: branchD=1, regwriteE=1, writeregE=3, rtD=3 → stallD=1, flushE=1. writeregE=0 → no stall.
- Mem wait: memaccessM=1, dmem_ready low for 3 cycles then high → stallF..M=1 and flushW=1 for 3 cycles, FSM back in IDLE, stall_cnt+=3, mem_err=0.
- Timeout: TIMEOUT=4, dmem_ready held 0 → mem_err=1 on the 4th edge and stays 1 after ready rises; reset=0 → mem_err=0, stall_cnt=0.
- Mem stall overlapping load-use: memstall=1 and lwstall=1 → flushE=0, stallE=1. Release ready → flushE=1 in that cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard resolver.
package hazard_pkg;

    // ALU operand source selects
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    // Data-memory wait tracker states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memwait_state_t;

    // Register $0 is hardwired to zero and never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Execute-stage forward select: the newer result in M beats the older one in W
    function automatic fwd_sel_t fwdSelect(
        input logic [4:0] src,
        input logic [4:0] wrM,
        input logic       regwrM,
        input logic [4:0] wrW,
        input logic       regwrW
    );
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (src != REG_ZERO && src == wrM && regwrM) begin
            sel = FWD_MEM;
        end else if (src != REG_ZERO && src == wrW && regwrW) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_memwait.sv
// Data-memory wait tracker: flags a stall whenever the M-stage access is not
// ready and raises a sticky error if the wait drags on for TIMEOUT cycles.
module hazard_memwait
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memaccessM,
    input  logic dmem_ready,
    output logic memstall,
    output logic mem_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    memwait_state_t  r_state;
    logic [CW-1:0]   r_waitCnt;
    logic            r_memErr;
    logic [CW-1:0]   w_cntInc;

    // The stall itself is purely combinational so the pipe freezes in the same cycle
    assign memstall = memaccessM && !dmem_ready;
    assign mem_err  = r_memErr;
    assign w_cntInc = r_waitCnt + CW'(1);

    // Track how long the current access has waited; the error stays set until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (memstall) begin
                        r_state   <= WAIT;
                        r_waitCnt <= CW'(1);
                        if (TMO == CW'(1)) begin
                            r_memErr <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ready || !memaccessM) begin
                        r_state   <= IDLE;
                        r_waitCnt <= '0;
                    end else if (r_waitCnt != TMO) begin
                        r_waitCnt <= w_cntInc;
                        if (w_cntInc == TMO) begin
                            r_memErr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage MIPS pipeline: forwarding selects, load-use
// and branch stalls, data-memory wait freezing and a stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             bneD,
    input  logic             memaccessM,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       w_memstall;
    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_eHit;
    logic       w_mHit;
    logic       w_stallFront;
    fwd_sel_t   w_fwdaE;
    fwd_sel_t   w_fwdbE;
    logic [CNT_W-1:0] r_stallCnt;

    hazard_memwait #(
        .TIMEOUT (TIMEOUT)
    ) u_memwait (
        .clk        (clk),
        .reset      (reset),
        .memaccessM (memaccessM),
        .dmem_ready (dmem_ready),
        .memstall   (w_memstall),
        .mem_err    (mem_err)
    );

    assign w_fwdaE = fwdSelect(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign w_fwdbE = fwdSelect(rtE, writeregM, regwriteM, writeregW, regwriteW);

    // A load in E cannot forward in time to an instruction in D that reads it
    assign w_lwstall = memtoregE && (rtE == rsD || rtE == rtD);

    // Branches compare in D, so an ALU result still in E or a load still in M must be waited on
    assign w_eHit = regwriteE && writeregE != REG_ZERO && (writeregE == rsD || writeregE == rtD);
    assign w_mHit = memtoregM && writeregM != REG_ZERO && (writeregM == rsD || writeregM == rtD);
    assign w_branchstall = (branchD | bneD) && (w_eHit || w_mHit);

    assign w_stallFront = w_lwstall | w_branchstall | w_memstall;

    // Every hazard output is forced quiet while reset is held
    assign stallF    = reset & w_stallFront;
    assign stallD    = reset & w_stallFront;
    assign stallE    = reset & w_memstall;
    assign stallM    = reset & w_memstall;
    assign flushE    = reset & (w_lwstall | w_branchstall) & ~w_memstall;
    assign flushW    = reset & w_memstall;
    assign forwardaD = reset & (rsD != REG_ZERO) & (rsD == writeregM) & regwriteM;
    assign forwardbD = reset & (rtD != REG_ZERO) & (rtD == writeregM) & regwriteM;
    assign forwardaE = reset ? w_fwdaE : FWD_NONE;
    assign forwardbE = reset ? w_fwdbE : FWD_NONE;
    assign stall_cnt = r_stallCnt;

    // Count cycles the decode stage was held, sticking at the top rather than wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
        end else if (stallD && r_stallCnt != '1) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a small expected-value scoreboard.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW;
    logic        memtoregE, memtoregM;
    logic        branchD, bneD;
    logic        memaccessM, dmem_ready;
    logic        stallF, stallD, stallE, stallM;
    logic        flushE, flushW;
    logic        forwardaD, forwardbD;
    logic [1:0]  forwardaE, forwardbE;
    logic        mem_err;
    logic [15:0] stall_cnt;
    logic [12:0] outVec;

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   nVec  = 0;
    int   nFail = 0;

    // Output bundle layout: stallF,D,E,M | flushE,W | fwdaD,bD | fwdaE | fwdbE | mem_err
    localparam logic [12:0] Z  = 13'b0000_00_00_00_00_0;
    localparam logic [12:0] LS = 13'b1100_10_00_00_00_0;
    localparam logic [12:0] MW = 13'b1111_01_00_00_00_0;

    hazard_unit #(
        .TIMEOUT (4),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rsD        (rsD),
        .rtD        (rtD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeregE  (writeregE),
        .writeregM  (writeregM),
        .writeregW  (writeregW),
        .regwriteE  (regwriteE),
        .regwriteM  (regwriteM),
        .regwriteW  (regwriteW),
        .memtoregE  (memtoregE),
        .memtoregM  (memtoregM),
        .branchD    (branchD),
        .bneD       (bneD),
        .memaccessM (memaccessM),
        .dmem_ready (dmem_ready),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushE     (flushE),
        .flushW     (flushW),
        .forwardaD  (forwardaD),
        .forwardbD  (forwardbD),
        .forwardaE  (forwardaE),
        .forwardbE  (forwardbE),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt)
    );

    assign outVec = {stallF, stallD, stallE, stallM, flushE, flushW,
                     forwardaD, forwardbD, forwardaE, forwardbE, mem_err};

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; bneD = 1'b0;
        memaccessM = 1'b0; dmem_ready = 1'b0;
    endtask

    // Record what the outputs must be for the inputs just driven, then let them settle
    task automatic applyStimulus(input string tag, input logic [12:0] vec, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag;          e.kind = 0; e.val = {3'b000, vec};
        sb.push_back(e);
        e.tag = {tag, ".cnt"}; e.kind = 1; e.val = cnt;
        sb.push_back(e);
        #2;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.kind == 0) ? {3'b000, outVec} : stall_cnt;
            nVec++;
            assert (obs === e.val) else begin
                nFail++;
                $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [12:0] vec, input logic [15:0] cnt);
        applyStimulus(tag, vec, cnt);
        checkOutput();
        nextCycle();
    endtask

    initial begin
        logic [12:0] v;

        // Reset held with hazardous inputs: everything must stay quiet
        reset = 1'b0;
        clearInputs();
        memaccessM = 1'b1; memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1'b1;
        step("rst_hold", Z, 16'd0);
        step("rst_hold2", Z, 16'd0);
        clearInputs();
        reset = 1'b1;
        step("rst_rel", Z, 16'd0);

        // Execute-stage forwarding
        writeregM = 5'd5; regwriteM = 1'b1; writeregW = 5'd5; regwriteW = 1'b1;
        rsE = 5'd5; rtE = 5'd5;
        step("fwdE_mem", 13'b0000_00_00_10_10_0, 16'd0);
        regwriteM = 1'b0;
        step("fwdE_wb", 13'b0000_00_00_01_01_0, 16'd0);
        regwriteM = 1'b1; rsE = 5'd0; rtE = 5'd0;
        step("fwdE_zero", Z, 16'd0);

        // Decode-stage forwarding
        rsD = 5'd5; rtD = 5'd6;
        step("fwdD_a", 13'b0000_00_10_00_00_0, 16'd0);
        rsD = 5'd0; rtD = 5'd5;
        step("fwdD_b", 13'b0000_00_01_00_00_0, 16'd0);
        clearInputs();

        // Load-use stall
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        step("lwstall", LS, 16'd0);
        memtoregE = 1'b0;
        step("lw_clear", Z, 16'd1);
        clearInputs();

        // Branch hazards
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rtD = 5'd3;
        step("br_stall", LS, 16'd1);
        writeregE = 5'd0;
        step("br_r0", Z, 16'd2);
        clearInputs();
        bneD = 1'b1; memtoregM = 1'b1; writeregM = 5'd4; rsD = 5'd4;
        step("bne_load", LS, 16'd2);
        clearInputs();
        step("br_clear", Z, 16'd3);

        // Data-memory wait, then a back-to-back access
        memaccessM = 1'b1;
        for (int k = 0; k < 3; k++) step("memwait", MW, 16'(3 + k));
        dmem_ready = 1'b1;
        step("mem_ready", Z, 16'd6);
        dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step("memwait2", MW, 16'(6 + k));
        dmem_ready = 1'b1;
        step("mem_ready2", Z, 16'd9);
        clearInputs();
        step("mem_idle", Z, 16'd9);

        // Memory stall overlapping a load-use hazard
        memaccessM = 1'b1; memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        step("ovl_mem", MW, 16'd9);
        dmem_ready = 1'b1;
        step("ovl_rel", LS, 16'd10);
        clearInputs();
        step("ovl_clear", Z, 16'd11);

        // Timeout: error rises after the fourth waiting edge and sticks
        memaccessM = 1'b1;
        for (int k = 0; k < 6; k++) begin
            v    = MW;
            v[0] = (k >= 4);
            step("timeout", v, 16'(11 + k));
        end
        dmem_ready = 1'b1;
        step("to_ready", 13'b0000_00_00_00_00_1, 16'd17);
        clearInputs();
        step("to_sticky", 13'b0000_00_00_00_00_1, 16'd17);

        // Asynchronous reset in the middle of a wait
        memaccessM = 1'b1;
        step("pre_rst", 13'b1111_01_00_00_00_1, 16'd17);
        reset = 1'b0;
        applyStimulus("rst_async", Z, 16'd0);
        checkOutput();
        nextCycle();
        clearInputs();
        reset = 1'b1;
        step("rst_done", Z, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
